// File: rtl/log_afpm_if.sv
// Byte-serial handshake bundle between the pin interface and the log_afpm_param multiplier.
interface log_afpm_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic [3:0] flags;

    modport master (
        output in_valid, a_byte, b_byte, mode, out_ready,
        input  in_ready, out_valid, out_byte, out_last, flags
    );

    modport slave (
        input  in_valid, a_byte, b_byte, mode, out_ready,
        output in_ready, out_valid, out_byte, out_last, flags
    );
endinterface

// File: rtl/log_afpm_param.sv
// Byte-serial approximate floating-point multiplier (Mitchell log multiply), generic in
// exponent/mantissa width, with optional error compensation and IEEE-style special cases.
module log_afpm_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    log_afpm_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int NBYTES = (W + 7) / 8;
    localparam int NB_W   = NBYTES * 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int E_W    = EXP_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [E_W-1:0]   BIAS     = E_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [E_W-1:0]   E_TOP    = E_W'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0] QNAN_M   = MAN_W'(1) << (MAN_W - 1);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        DECODE  = 3'd1,
        LOGADD  = 3'd2,
        NORM    = 3'd3,
        EMIT    = 3'd4
    } state_t;

    function automatic logic [7:0] pick_byte(input logic [NB_W-1:0] word,
                                             input logic [IDX_W-1:0] k);
        logic [7:0] sel;
        sel = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == IDX_W'(i)) begin
                sel = word[i*8 +: 8];
            end
        end
        return sel;
    endfunction

    state_t           state_d, state_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [NB_W-1:0]  a_d, a_q, b_d, b_q;
    logic             mode_d, mode_q;
    logic             s_d, s_q;
    logic [EXP_W-1:0] ea_d, ea_q, eb_d, eb_q;
    logic [MAN_W-1:0] ma_d, ma_q, mb_d, mb_q;
    logic             inv_d, inv_q, inf_d, inf_q, zin_d, zin_q;
    logic [MAN_W-1:0] f_d, f_q;
    logic [E_W-1:0]   e_d, e_q;
    logic [NB_W-1:0]  res_d, res_q;
    logic             in_ready_d, in_ready_q;
    logic             out_valid_d, out_valid_q;
    logic             out_last_d, out_last_q;
    logic [7:0]       out_byte_d, out_byte_q;
    logic [3:0]       flags_d, flags_q;

    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W-1:0] ma_s, mb_s;
    logic             a_zero_s, b_zero_s, a_spec_s, b_spec_s, a_nan_s, b_nan_s;
    logic [MAN_W:0]   msum_s;
    logic [MAN_W-1:0] fc_s, m_s;
    logic [W-1:0]     res_s;
    logic [NB_W-1:0]  res_pad_s;
    logic [3:0]       flg_s;
    logic [IDX_W-1:0] idx_inc_s;

    // Operand field split, log-domain mantissa sum, correction term and special-case result.
    always_comb begin
        ea_s     = a_q[W-2 -: EXP_W];
        eb_s     = b_q[W-2 -: EXP_W];
        ma_s     = a_q[MAN_W-1:0];
        mb_s     = b_q[MAN_W-1:0];
        a_zero_s = (ea_s == {EXP_W{1'b0}});
        b_zero_s = (eb_s == {EXP_W{1'b0}});
        a_spec_s = (ea_s == {EXP_W{1'b1}});
        b_spec_s = (eb_s == {EXP_W{1'b1}});
        a_nan_s  = a_spec_s && (ma_s != {MAN_W{1'b0}});
        b_nan_s  = b_spec_s && (mb_s != {MAN_W{1'b0}});
        msum_s   = {1'b0, ma_q} + {1'b0, mb_q};
        idx_inc_s = idx_q + IDX_W'(1);

        // Compensation folds the fraction around 0.5 so the added error term peaks mid-range.
        if (f_q[MAN_W-1]) begin
            fc_s = ~f_q;
        end else begin
            fc_s = f_q;
        end
        if (mode_q) begin
            m_s = f_q + (fc_s >> 2'd3);
        end else begin
            m_s = f_q;
        end

        if (inv_q) begin
            res_s = {s_q, {EXP_W{1'b1}}, QNAN_M};
            flg_s = 4'b1000;
        end else if (inf_q) begin
            res_s = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_s = 4'b0100;
        end else if (zin_q) begin
            res_s = {s_q, {(EXP_W + MAN_W){1'b0}}};
            flg_s = 4'b0001;
        end else if (!e_q[E_W-1] && (e_q >= E_TOP)) begin
            res_s = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_s = 4'b0100;
        end else if (e_q[E_W-1] || (e_q == {E_W{1'b0}})) begin
            res_s = {s_q, {(EXP_W + MAN_W){1'b0}}};
            flg_s = 4'b0011;
        end else begin
            res_s = {s_q, e_q[EXP_W-1:0], m_s};
            flg_s = 4'b0000;
        end
        res_pad_s = {NB_W{1'b0}};
        res_pad_s[W-1:0] = res_s;
    end

    // Next-state and next-output logic for the collect/compute/emit sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        s_d         = s_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        inv_d       = inv_q;
        inf_d       = inf_q;
        zin_d       = zin_q;
        f_d         = f_q;
        e_d         = e_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_byte_d  = out_byte_q;
        flags_d     = flags_q;

        case (state_q)
            COLLECT: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            a_d[i*8 +: 8] = bus.a_byte;
                            b_d[i*8 +: 8] = bus.b_byte;
                        end else begin
                            a_d[i*8 +: 8] = a_q[i*8 +: 8];
                            b_d[i*8 +: 8] = b_q[i*8 +: 8];
                        end
                    end
                    if (idx_q == {IDX_W{1'b0}}) begin
                        mode_d = bus.mode;
                    end else begin
                        mode_d = mode_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = DECODE;
                    end else begin
                        idx_d   = idx_inc_s;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            DECODE: begin
                s_d     = a_q[W-1] ^ b_q[W-1];
                ea_d    = ea_s;
                eb_d    = eb_s;
                ma_d    = ma_s;
                mb_d    = mb_s;
                inv_d   = (a_zero_s && b_spec_s) || (b_zero_s && a_spec_s) || a_nan_s || b_nan_s;
                inf_d   = a_spec_s || b_spec_s;
                zin_d   = a_zero_s || b_zero_s;
                state_d = LOGADD;
            end
            LOGADD: begin
                f_d     = msum_s[MAN_W-1:0];
                e_d     = {2'b00, ea_q} + {2'b00, eb_q}
                        + {{(E_W - 1){1'b0}}, msum_s[MAN_W]} - BIAS;
                state_d = NORM;
            end
            NORM: begin
                res_d       = res_pad_s;
                flags_d     = flg_s;
                out_valid_d = 1'b1;
                out_byte_d  = pick_byte(res_pad_s, {IDX_W{1'b0}});
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = {IDX_W{1'b0}};
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_byte_d  = 8'h00;
                        flags_d     = 4'b0000;
                        state_d     = COLLECT;
                    end else begin
                        idx_d       = idx_inc_s;
                        out_byte_d  = pick_byte(res_q, idx_inc_s);
                        out_last_d  = (idx_inc_s == LAST_IDX);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                idx_d       = {IDX_W{1'b0}};
                out_valid_d = 1'b0;
                state_d     = COLLECT;
            end
        endcase

        in_ready_d = (state_d == COLLECT);
    end

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= {IDX_W{1'b0}};
            a_q         <= {NB_W{1'b0}};
            b_q         <= {NB_W{1'b0}};
            mode_q      <= 1'b0;
            s_q         <= 1'b0;
            ea_q        <= {EXP_W{1'b0}};
            eb_q        <= {EXP_W{1'b0}};
            ma_q        <= {MAN_W{1'b0}};
            mb_q        <= {MAN_W{1'b0}};
            inv_q       <= 1'b0;
            inf_q       <= 1'b0;
            zin_q       <= 1'b0;
            f_q         <= {MAN_W{1'b0}};
            e_q         <= {E_W{1'b0}};
            res_q       <= {NB_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_byte_q  <= 8'h00;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            s_q         <= s_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            inv_q       <= inv_d;
            inf_q       <= inf_d;
            zin_q       <= zin_d;
            f_q         <= f_d;
            e_q         <= e_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_byte_q  <= out_byte_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_log_afpm_param.sv
// Directed bench for log_afpm_param: FP16 instance plus a 1-byte (EXP_W=4, MAN_W=3) instance.
module tb_log_afpm_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    log_afpm_if bus16();
    log_afpm_if bus8();

    log_afpm_param dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    log_afpm_param #(.EXP_W(4), .MAN_W(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic m);
        int t;
        t = 0;
        while (bus16.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send16_ready: in_ready=%b required 1", bus16.in_ready);
        end
        bus16.in_valid = 1'b1;
        bus16.a_byte   = a[7:0];
        bus16.b_byte   = b[7:0];
        bus16.mode     = m;
        @(negedge clk);
        bus16.a_byte   = a[15:8];
        bus16.b_byte   = b[15:8];
        bus16.mode     = ~m;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.a_byte   = 8'h00;
        bus16.b_byte   = 8'h00;
        bus16.mode     = 1'b0;
    endtask

    task automatic xact16(input logic [15:0] a, input logic [15:0] b, input logic m,
                          output logic [15:0] res, output logic [3:0] flg,
                          output int lat, output logic pok);
        logic       l0, l1;
        logic [3:0] f1;
        send16(a, b, m);
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res[7:0] = bus16.out_byte;
        l0       = bus16.out_last;
        flg      = bus16.flags;
        @(negedge clk);
        res[15:8] = bus16.out_byte;
        l1        = bus16.out_last;
        f1        = bus16.flags;
        pok = (l0 === 1'b0) && (l1 === 1'b1) && (f1 === flg) && (bus16.out_valid === 1'b1);
        @(negedge clk);
        pok = pok && (bus16.out_valid === 1'b0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.out_last, bus16.flags, bus16.out_byte} !== 15'h0000) begin
            n_fail++;
            $display("FAIL reset16_outputs: rdy=%b vld=%b last=%b flags=%h byte=%h required all 0",
                     bus16.in_ready, bus16.out_valid, bus16.out_last, bus16.flags, bus16.out_byte);
        end
        n_checks++;
        if ({bus8.in_ready, bus8.out_valid, bus8.out_last, bus8.flags, bus8.out_byte} !== 15'h0000) begin
            n_fail++;
            $display("FAIL reset8_outputs: rdy=%b vld=%b byte=%h required all 0",
                     bus8.in_ready, bus8.out_valid, bus8.out_byte);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus16.in_ready, bus8.in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready16=%b in_ready8=%b required 1 1",
                     bus16.in_ready, bus8.in_ready);
        end
    endtask

    task automatic test_basic;
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        logic        pok;
        xact16(16'h4000, 16'h4200, 1'b0, res, flg, lat, pok);
        n_checks++;
        if (res !== 16'h4600) begin
            n_fail++;
            $display("FAIL basic_result: got %h required 4600", res);
        end
        n_checks++;
        if (flg !== 4'h0) begin
            n_fail++;
            $display("FAIL basic_flags: got %b required 0000", flg);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 3", lat);
        end
        n_checks++;
        if (pok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_protocol: out_last/flags/out_valid sequence got %b required 1", pok);
        end
    endtask

    task automatic test_mitchell;
        logic [52:0] vec [3];
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        logic        pok;
        vec = '{{16'h3D00, 16'h3D00, 1'b0, 16'h3E00, 4'h0},
                {16'h3D00, 16'h3D00, 1'b1, 16'h3E3F, 4'h0},
                {16'h3E00, 16'h3E00, 1'b0, 16'h4000, 4'h0}};
        for (int i = 0; i < 3; i++) begin
            xact16(vec[i][52:37], vec[i][36:21], vec[i][20], res, flg, lat, pok);
            n_checks++;
            if ({res, flg, pok} !== {vec[i][19:0], 1'b1}) begin
                n_fail++;
                $display("FAIL mitchell[%0d]: got res=%h flags=%b proto=%b required res=%h flags=%b proto=1",
                         i, res, flg, pok, vec[i][19:4], vec[i][3:0]);
            end
        end
    endtask

    task automatic test_special;
        logic [52:0] vec [3];
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        logic        pok;
        vec = '{{16'h7800, 16'h7800, 1'b0, 16'h7C00, 4'b0100},
                {16'hF800, 16'h7800, 1'b0, 16'hFC00, 4'b0100},
                {16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000}};
        for (int i = 0; i < 3; i++) begin
            xact16(vec[i][52:37], vec[i][36:21], vec[i][20], res, flg, lat, pok);
            n_checks++;
            if ({res, flg, pok} !== {vec[i][19:0], 1'b1}) begin
                n_fail++;
                $display("FAIL special[%0d]: got res=%h flags=%b proto=%b required res=%h flags=%b proto=1",
                         i, res, flg, pok, vec[i][19:4], vec[i][3:0]);
            end
        end
    endtask

    task automatic test_zero_underflow;
        logic [52:0] vec [3];
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        logic        pok;
        vec = '{{16'h0000, 16'h4000, 1'b0, 16'h0000, 4'b0001},
                {16'h0400, 16'h0400, 1'b0, 16'h0000, 4'b0011},
                {16'h8400, 16'h0400, 1'b0, 16'h8000, 4'b0011}};
        for (int i = 0; i < 3; i++) begin
            xact16(vec[i][52:37], vec[i][36:21], vec[i][20], res, flg, lat, pok);
            n_checks++;
            if ({res, flg, pok} !== {vec[i][19:0], 1'b1}) begin
                n_fail++;
                $display("FAIL zero_uflow[%0d]: got res=%h flags=%b proto=%b required res=%h flags=%b proto=1",
                         i, res, flg, pok, vec[i][19:4], vec[i][3:0]);
            end
        end
    endtask

    task automatic test_hold;
        int t;
        bus16.out_ready = 1'b0;
        send16(16'h3D00, 16'h3D00, 1'b1);
        t = 0;
        while (bus16.out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus16.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_valid: out_valid=%b required 1", bus16.out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus16.out_valid, bus16.in_ready, bus16.out_last, bus16.flags, bus16.out_byte}
                    !== {1'b1, 1'b0, 1'b0, 4'h0, 8'h3F}) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: vld=%b rdy=%b last=%b flags=%b byte=%h required 1 0 0 0000 3f",
                         c, bus16.out_valid, bus16.in_ready, bus16.out_last, bus16.flags, bus16.out_byte);
            end
        end
        bus16.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus16.out_valid, bus16.out_last, bus16.out_byte} !== {1'b1, 1'b1, 8'h3E}) begin
            n_fail++;
            $display("FAIL hold_byte1: vld=%b last=%b byte=%h required 1 1 3e",
                     bus16.out_valid, bus16.out_last, bus16.out_byte);
        end
        @(negedge clk);
        n_checks++;
        if (bus16.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_drop: out_valid=%b required 0", bus16.out_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        logic        pok;
        bus16.in_valid = 1'b1;
        bus16.a_byte   = 8'hAA;
        bus16.b_byte   = 8'h55;
        bus16.mode     = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.out_last, bus16.flags, bus16.out_byte} !== 15'h0000) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b byte=%h required all 0",
                     bus16.in_ready, bus16.out_valid, bus16.out_byte);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact16(16'h4000, 16'h4200, 1'b0, res, flg, lat, pok);
        n_checks++;
        if ({res, flg, pok} !== {16'h4600, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_next: got res=%h flags=%b proto=%b required 4600 0000 1", res, flg, pok);
        end
    endtask

    task automatic test_small;
        int t;
        t = 0;
        while (bus8.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        bus8.in_valid = 1'b1;
        bus8.a_byte   = 8'h40;
        bus8.b_byte   = 8'h44;
        bus8.mode     = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        t = 0;
        while (bus8.out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if ({bus8.out_byte, bus8.out_last, bus8.flags} !== {8'h4C, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL small_result: byte=%h last=%b flags=%b required 4c 1 0000",
                     bus8.out_byte, bus8.out_last, bus8.flags);
        end
        n_checks++;
        if (t !== 3) begin
            n_fail++;
            $display("FAIL small_latency: got %0d required 3", t);
        end
        @(negedge clk);
        n_checks++;
        if (bus8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL small_drop: out_valid=%b required 0", bus8.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  opa [7];
        logic [7:0]  opb [7];
        logic [12:0] expv [7];
        int          k, j, extra;
        opa  = '{8'h40, 8'h38, 8'h3A, 8'hC0, 8'h44, 8'h70, 8'h08};
        opb  = '{8'h44, 8'h38, 8'h3A, 8'h40, 8'h44, 8'h70, 8'h08};
        expv = '{{4'b0000, 1'b1, 8'h4C}, {4'b0000, 1'b1, 8'h38}, {4'b0000, 1'b1, 8'h3C},
                 {4'b0000, 1'b1, 8'hC8}, {4'b0000, 1'b1, 8'h50}, {4'b0100, 1'b1, 8'h78},
                 {4'b0011, 1'b1, 8'h00}};
        k = 0;
        j = 0;
        bus8.out_ready = 1'b1;
        bus8.mode      = 1'b0;
        bus8.a_byte    = opa[0];
        bus8.b_byte    = opb[0];
        bus8.in_valid  = 1'b1;
        fork
            begin
                int  t;
                logic acc;
                t = 0;
                while (k < 7 && t < 400) begin
                    acc = bus8.in_ready;
                    @(negedge clk);
                    t++;
                    if (acc) begin
                        k++;
                        if (k < 7) begin
                            bus8.a_byte = opa[k];
                            bus8.b_byte = opb[k];
                        end
                    end
                end
                bus8.in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (j < 7 && t < 400) begin
                    @(negedge clk);
                    t++;
                    if (bus8.out_valid === 1'b1) begin
                        n_checks++;
                        if ({bus8.flags, bus8.out_last, bus8.out_byte} !== expv[j]) begin
                            n_fail++;
                            $display("FAIL b2b[%0d]: flags=%b last=%b byte=%h required %b %b %h",
                                     j, bus8.flags, bus8.out_last, bus8.out_byte,
                                     expv[j][12:9], expv[j][8], expv[j][7:0]);
                        end
                        j++;
                    end
                end
            end
        join
        n_checks++;
        if (k !== 7 || j !== 7) begin
            n_fail++;
            $display("FAIL b2b_counts: accepted=%0d emitted=%0d required 7 7", k, j);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus8.out_valid === 1'b1) begin
                extra++;
            end
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL b2b_extra: %0d unexpected output cycles required 0", extra);
        end
    endtask

    initial begin
        bus16.in_valid  = 1'b0;
        bus16.a_byte    = 8'h00;
        bus16.b_byte    = 8'h00;
        bus16.mode      = 1'b0;
        bus16.out_ready = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.a_byte     = 8'h00;
        bus8.b_byte     = 8'h00;
        bus8.mode       = 1'b0;
        bus8.out_ready  = 1'b1;
        test_reset;
        test_basic;
        test_mitchell;
        test_special;
        test_zero_underflow;
        test_hold;
        test_reset_mid;
        test_small;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
